// File: rtl/mul_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arb_pkg
// Description : Shared widths, id-width derivation, request-slice helper and
//               result-pipeline stage record for the shared multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_share_arb_pkg;

    localparam int c_din0_w   = 16;
    localparam int c_din1_w   = 9;
    localparam int c_dout_w   = 23;
    localparam int c_max_req  = 8;
    localparam int c_max_id_w = 3;

    // Minimum one bit so a two-requester build still has a usable id.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // LSB position of requester idx inside a packed operand bus.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    typedef struct packed {
        logic                  vld;
        logic [c_max_id_w-1:0] id;
        logic [c_dout_w-1:0]   dout;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/mul_core_16s_9s.sv
`default_nettype none
// ============================================================================
// Module      : mul_core_16s_9s
// Description : Combinational signed 16x9 multiply, result wrapped to 23 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_core_16s_9s
    import mul_share_arb_pkg::*;
(
    input  logic [c_din0_w-1:0] i_din0,
    input  logic [c_din1_w-1:0] i_din1,
    output logic [c_dout_w-1:0] o_dout
);

    logic signed [c_dout_w-1:0] w_a;
    logic signed [c_dout_w-1:0] w_b;

    assign w_a = {{(c_dout_w - c_din0_w){i_din0[c_din0_w-1]}}, i_din0};
    assign w_b = {{(c_dout_w - c_din1_w){i_din1[c_din1_w-1]}}, i_din1};

    // Multiplying at the result width yields exactly the low bits of the
    // full 25-bit product, i.e. two's-complement wrap.
    assign o_dout = w_a * w_b;

endmodule
`default_nettype wire

// File: rtl/mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arb
// Description : Round-robin time-sharing of one signed 16x9 multiplier among
//               N_REQ requesters, with an id-tagged stallable result pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DIN0_W = c_din0_w,
    parameter int DIN1_W = c_din1_w,
    parameter int DOUT_W = c_dout_w,
    parameter int PIPE   = 2,
    parameter int ID_W   = id_width(N_REQ)
)(
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [N_REQ-1:0]          req_vld,
    output logic [N_REQ-1:0]          req_rdy,
    input  logic [N_REQ*DIN0_W-1:0]   req_din0,
    input  logic [N_REQ*DIN1_W-1:0]   req_din1,
    output logic                      res_vld,
    input  logic                      res_rdy,
    output logic [DOUT_W-1:0]         res_dout,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy,
    output logic [31:0]               ops_cnt
);

    stage_t             r_stage [PIPE];
    logic [ID_W-1:0]    r_ptr;
    logic [31:0]        r_ops_cnt;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_stall;
    logic               w_accept;
    logic               w_busy;
    logic [DIN0_W-1:0]  w_din0;
    logic [DIN1_W-1:0]  w_din1;
    logic [DOUT_W-1:0]  w_prod;

    // Round-robin search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_idx    = '0;
        w_any    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_any && req_vld[w_idx]) begin
                w_any          = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gnt_id       = w_idx;
            end
        end
    end

    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_din0 = req_din0[slice_lsb(k, DIN0_W) +: DIN0_W];
                w_din1 = req_din1[slice_lsb(k, DIN1_W) +: DIN1_W];
            end
        end
    end

    mul_core_16s_9s u_mul (
        .i_din0 (w_din0),
        .i_din1 (w_din1),
        .o_dout (w_prod)
    );

    assign w_stall  = r_stage[PIPE-1].vld & ~res_rdy;
    assign w_accept = w_any & ~w_stall;
    assign req_rdy  = w_grant & {N_REQ{~w_stall}};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < PIPE; i++) begin
                r_stage[i] <= '0;
            end
            r_ptr     <= '0;
            r_ops_cnt <= '0;
        end else begin
            // Whole pipe advances together; a stall at the output freezes it.
            if (!w_stall) begin
                r_stage[0] <= '{vld:  w_any,
                                id:   c_max_id_w'(w_gnt_id),
                                dout: w_prod};
                for (int i = 1; i < PIPE; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
            if (w_accept) begin
                r_ptr <= ID_W'((int'(w_gnt_id) + 1) % N_REQ);
            end
            if (r_stage[PIPE-1].vld && res_rdy) begin
                r_ops_cnt <= r_ops_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < PIPE; i++) begin
            w_busy = w_busy | r_stage[i].vld;
        end
    end

    assign res_vld  = r_stage[PIPE-1].vld;
    assign res_dout = r_stage[PIPE-1].dout;
    assign res_id   = ID_W'(r_stage[PIPE-1].id);
    assign busy     = w_busy;
    assign ops_cnt  = r_ops_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_arb
// Description : Directed self-checking bench for mul_share_arb (N_REQ=4, PIPE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_arb;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_rdy;
    logic [N*16-1:0]   req_din0;
    logic [N*9-1:0]    req_din1;
    logic              res_vld;
    logic              res_rdy;
    logic [22:0]       res_dout;
    logic [ID_W-1:0]   res_id;
    logic              busy;
    logic [31:0]       ops_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] pend;
    logic [N-1:0] last_acc;
    logic [15:0]  hold0 [N];
    logic [8:0]   hold1 [N];
    int           quota [N];

    typedef struct {
        int          idx;
        logic [15:0] d0;
        logic [8:0]  d1;
        logic [22:0] exp;
    } vec_t;
    vec_t tv [5];

    mul_share_arb #(.N_REQ(N), .PIPE(2)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .res_dout (res_dout),
        .res_id   (res_id),
        .busy     (busy),
        .ops_cnt  (ops_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; a pending requester must keep valid and operands stable.
    task automatic step();
        @(negedge ap_clk);
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                n_tests++;
                if (!req_vld[i] || req_din0[i*16 +: 16] !== hold0[i] ||
                    req_din1[i*9 +: 9] !== hold1[i]) begin
                    n_fail++;
                    $display("FAIL hold_req%0d: got vld=%0b expected vld=1 with stable operands",
                             i, req_vld[i]);
                end
            end
            pend[i]  = !ap_rst && req_vld[i] && !req_rdy[i];
            hold0[i] = req_din0[i*16 +: 16];
            hold1[i] = req_din1[i*9 +: 9];
        end
        last_acc = req_vld & req_rdy;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic consume_quota();
        for (int i = 0; i < N; i++) begin
            if (last_acc[i]) quota[i] = quota[i] - 1;
            req_vld[i] = (quota[i] > 0);
        end
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
    endtask

    task automatic set_ops();
        for (int i = 0; i < N; i++) begin
            req_din0[i*16 +: 16] = 16'(i + 1);
            req_din1[i*9 +: 9]   = 9'd2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        req_vld  = '0;
        req_din0 = '0;
        req_din1 = '0;
        res_rdy  = 1'b1;
        ap_rst   = 1'b1;
        pend     = '0;
        last_acc = '0;
        for (int i = 0; i < N; i++) quota[i] = 0;

        tv[0] = '{0, 16'd100,  -9'sd3,  -23'sd300};
        tv[1] = '{1, 16'h8000, 9'h100,  23'd0};
        tv[2] = '{2, 16'h7fff, 9'h0ff,  -23'sd33023};
        tv[3] = '{3, 16'hffff, 9'h1ff,  23'd1};
        tv[4] = '{1, 16'd1234, -9'sd77, -23'sd95018};

        step();
        step();
        ap_rst = 1'b0;
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_dout", 32'(res_dout), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_ops_cnt", ops_cnt, 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);

        // Single operations: latency, arithmetic incl. wrap corners, busy, count.
        for (int t = 0; t < 5; t++) begin
            req_din0[tv[t].idx*16 +: 16] = tv[t].d0;
            req_din1[tv[t].idx*9 +: 9]   = tv[t].d1;
            req_vld = N'(1 << tv[t].idx);
            #1;
            chk("vec_rdy", 32'(req_rdy), 32'(1 << tv[t].idx));
            step();
            req_vld = '0;
            chk("vec_vld_early", 32'(res_vld), 32'd0);
            chk("vec_busy_inflight", 32'(busy), 32'd1);
            step();
            chk("vec_vld", 32'(res_vld), 32'd1);
            chk("vec_dout", 32'(res_dout), 32'(tv[t].exp));
            chk("vec_id", 32'(res_id), 32'(tv[t].idx));
            step();
            chk("vec_vld_done", 32'(res_vld), 32'd0);
            chk("vec_busy_idle", 32'(busy), 32'd0);
            chk("vec_ops_cnt", ops_cnt, 32'(t + 1));
        end

        // Round robin with all four requesters, two ops each.
        do_reset();
        set_ops();
        for (int i = 0; i < N; i++) quota[i] = 2;
        req_vld = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(req_rdy), 32'(1 << (k % 4)));
            step();
            consume_quota();
            if (k >= 1) begin
                chk("rr_vld", 32'(res_vld), 32'd1);
                chk("rr_id", 32'(res_id), 32'((k - 1) % 4));
                chk("rr_dout", 32'(res_dout), 32'(((k - 1) % 4 + 1) * 2));
            end
        end
        step();
        chk("rr_last_id", 32'(res_id), 32'd3);
        chk("rr_last_dout", 32'(res_dout), 32'd8);
        step();
        chk("rr_drained", 32'(res_vld), 32'd0);
        chk("rr_ops_cnt", ops_cnt, 32'd8);
        chk("rr_busy", 32'(busy), 32'd0);

        // Sparse fairness: only requesters 1 and 3.
        quota[0] = 0; quota[1] = 2; quota[2] = 0; quota[3] = 2;
        req_vld = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sp_grant", 32'(req_rdy), (k % 2 == 0) ? 32'd2 : 32'd8);
            step();
            consume_quota();
            if (k >= 1) begin
                chk("sp_id", 32'(res_id), ((k - 1) % 2 == 0) ? 32'd1 : 32'd3);
                chk("sp_dout", 32'(res_dout), ((k - 1) % 2 == 0) ? 32'd4 : 32'd8);
            end
        end
        step();
        chk("sp_last_id", 32'(res_id), 32'd3);
        step();
        chk("sp_drained", 32'(res_vld), 32'd0);
        chk("sp_ops_cnt", ops_cnt, 32'd12);

        // Backpressure: five cycles of res_rdy=0 with a continuous stream.
        for (int i = 0; i < N; i++) quota[i] = 2;
        req_vld = '1;
        res_rdy = 1'b0;
        #1;
        chk("bp_grant0", 32'(req_rdy), 32'd1);
        step();
        consume_quota();
        chk("bp_grant1", 32'(req_rdy), 32'd2);
        step();
        consume_quota();
        chk("bp_fill_vld", 32'(res_vld), 32'd1);
        chk("bp_fill_id", 32'(res_id), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_rdy_low", 32'(req_rdy), 32'd0);
            step();
            consume_quota();
            chk("bp_hold_vld", 32'(res_vld), 32'd1);
            chk("bp_hold_id", 32'(res_id), 32'd0);
            chk("bp_hold_dout", 32'(res_dout), 32'd2);
            chk("bp_hold_busy", 32'(busy), 32'd1);
        end
        res_rdy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("bp_rel_grant", 32'(req_rdy), 32'(1 << ((2 + j) % 4)));
            step();
            consume_quota();
            chk("bp_rel_vld", 32'(res_vld), 32'd1);
            chk("bp_rel_id", 32'(res_id), 32'((j + 1) % 4));
            chk("bp_rel_dout", 32'(res_dout), 32'(((j + 1) % 4 + 1) * 2));
        end
        step();
        chk("bp_last_id", 32'(res_id), 32'd3);
        step();
        chk("bp_drained", 32'(res_vld), 32'd0);
        chk("bp_ops_cnt", ops_cnt, 32'd20);

        // Reset while two results are in flight.
        req_vld = '1;
        step();
        step();
        chk("mr_inflight_busy", 32'(busy), 32'd1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("mr_res_vld", 32'(res_vld), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ops_cnt", ops_cnt, 32'd0);
        chk("mr_res_dout", 32'(res_dout), 32'd0);
        #1;
        chk("mr_ptr_grant", 32'(req_rdy), 32'd1);
        req_vld = 4'b0001;
        step();
        req_vld = '0;
        chk("mr_no_stale", 32'(res_vld), 32'd0);
        step();
        chk("mr_post_vld", 32'(res_vld), 32'd1);
        chk("mr_post_id", 32'(res_id), 32'd0);
        chk("mr_post_dout", 32'(res_dout), 32'd2);
        step();
        chk("mr_post_done", 32'(res_vld), 32'd0);
        chk("mr_post_ops", ops_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
